// File: rtl/avg_channel_scheduler_pkg.sv
// Shared sample width, channel-count limit and the widened sum type for the
// channel-scheduled moving-average block.
package avg_channel_scheduler_pkg;

  localparam int word_width       = 16;
  localparam int AVG_SCHED_MAX_CH = 4;

  // One extra bit so the two-tap sum of signed samples never overflows.
  typedef logic [word_width:0] avg_sum_t;

endpackage

// File: rtl/avg_channel_scheduler_rr_pick.sv
// Round-robin picker: zero latency; the first request at or above ptr wins,
// wrapping modulo NUM_CH. No backpressure; it only reports a choice.
module rr_pick
  import avg_channel_scheduler_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic              gnt_vld,
  output logic [CH_W-1:0]   gnt_idx
);

  logic [CH_W:0]   wide;
  logic [CH_W-1:0] idx;

  // Walk offsets from farthest to nearest so the closest request overwrites.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    wide    = '0;
    idx     = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      wide = {1'b0, ptr} + (CH_W + 1)'(k);
      if (wide >= (CH_W + 1)'(NUM_CH)) begin
        wide = wide - (CH_W + 1)'(NUM_CH);
      end
      idx = wide[CH_W-1:0];
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/avg_channel_scheduler.sv
// Shares one two-tap averager across NUM_CH streams; output 2 cycles after capture when uncontested.
// No backpressure: a full, ungranted slot drops new samples (sticky overflow); AVG_SCHED_DROP_CNT_EN adds drop_cnt.
module avg_channel_scheduler
  import avg_channel_scheduler_pkg::*;
#(
  parameter  int NUM_CH = 2,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            ch_enable,
  input  logic [NUM_CH*word_width-1:0] ch_sample_in,
  input  logic [NUM_CH-1:0]            ch_sample_valid,
  input  logic                         hist_clr,
  input  logic                         overflow_clr,
  output logic [NUM_CH-1:0]            ch_busy,
  output logic [word_width-1:0]        sample_out,
  output logic [CH_W-1:0]              sample_out_ch,
  output logic                         sample_out_valid,
  output logic [NUM_CH-1:0]            overflow
`ifdef AVG_SCHED_DROP_CNT_EN
  ,
  output logic [NUM_CH*8-1:0]          drop_cnt
`endif
);

  if (NUM_CH < 2 || NUM_CH > AVG_SCHED_MAX_CH) begin : g_num_ch_check
    $error("avg_channel_scheduler: NUM_CH out of range");
  end

  logic [NUM_CH-1:0]     slot_vld;
  logic [word_width-1:0] slot_dat [NUM_CH];
  logic [word_width-1:0] hist     [NUM_CH];
  logic [CH_W-1:0]       rr_ptr;

  logic                  gnt_vld;
  logic [CH_W-1:0]       gnt_idx;
  logic [NUM_CH-1:0]     gnt_oh;
  logic [NUM_CH-1:0]     take;
  logic [NUM_CH-1:0]     drop;
  logic [word_width-1:0] gnt_dat;
  logic [word_width-1:0] gnt_hist;
  logic [word_width-1:0] avg_dat;
  avg_sum_t              sum;

  rr_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_rr_pick (
    .req     (slot_vld),
    .ptr     (rr_ptr),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    gnt_oh = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      gnt_oh[i] = gnt_vld && (gnt_idx == CH_W'(i));
    end
  end

  // A slot being granted this cycle frees up in time to accept a new sample.
  always_comb begin
    take = '0;
    drop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      take[i] = ch_sample_valid[i] && (!slot_vld[i] || gnt_oh[i]);
      drop[i] = ch_sample_valid[i] && slot_vld[i] && !gnt_oh[i];
    end
  end

  assign gnt_dat  = slot_dat[gnt_idx];
  assign gnt_hist = hist[gnt_idx];
  assign sum      = {gnt_dat[word_width-1], gnt_dat} + {gnt_hist[word_width-1], gnt_hist};
  assign avg_dat  = word_width'($signed(sum) >>> 1);
  assign ch_busy  = slot_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_vld <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        slot_dat[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (take[i]) begin
          slot_vld[i] <= 1'b1;
          slot_dat[i] <= ch_sample_in[i*word_width +: word_width];
        end else if (gnt_oh[i]) begin
          slot_vld[i] <= 1'b0;
        end
      end
    end
  end

  // The granted output already used the old history, so the clear can win.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        hist[i] <= '0;
      end
    end else if (hist_clr) begin
      for (int i = 0; i < NUM_CH; i++) begin
        hist[i] <= '0;
      end
    end else if (gnt_vld) begin
      hist[gnt_idx] <= gnt_dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (gnt_vld) begin
      rr_ptr <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= '0;
    end else begin
      overflow <= drop | (overflow & ~{NUM_CH{overflow_clr}});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_out_valid <= 1'b0;
      sample_out       <= '0;
      sample_out_ch    <= '0;
    end else begin
      sample_out_valid <= gnt_vld;
      if (gnt_vld) begin
        sample_out    <= ch_enable[gnt_idx] ? avg_dat : gnt_dat;
        sample_out_ch <= gnt_idx;
      end
    end
  end

`ifdef AVG_SCHED_DROP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (drop[i]) begin
          if (drop_cnt[i*8 +: 8] != 8'hFF) begin
            drop_cnt[i*8 +: 8] <= drop_cnt[i*8 +: 8] + 8'd1;
          end
        end else if (overflow_clr) begin
          drop_cnt[i*8 +: 8] <= '0;
        end
      end
    end
  end
`else
  // Without counters, drops are visible only through overflow.
`endif

endmodule

// File: tb/tb_avg_channel_scheduler.sv
// Directed bench for avg_channel_scheduler with a scoreboard of expected
// {channel, value, cycle} entries checked whenever an output strobe appears.
module tb_avg_channel_scheduler;
  import avg_channel_scheduler_pkg::*;

  localparam int NCH = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NCH-1:0]            ch_enable;
  logic [NCH*word_width-1:0] ch_sample_in;
  logic [NCH-1:0]            ch_sample_valid;
  logic                      hist_clr;
  logic                      overflow_clr;
  logic [NCH-1:0]            ch_busy;
  logic [word_width-1:0]     sample_out;
  logic                      sample_out_ch;
  logic                      sample_out_valid;
  logic [NCH-1:0]            overflow;
`ifdef AVG_SCHED_DROP_CNT_EN
  logic [NCH*8-1:0]          drop_cnt;
`endif

  avg_channel_scheduler #(.NUM_CH(NCH)) dut (
    .clk              (clk),
    .rst              (rst),
    .ch_enable        (ch_enable),
    .ch_sample_in     (ch_sample_in),
    .ch_sample_valid  (ch_sample_valid),
    .hist_clr         (hist_clr),
    .overflow_clr     (overflow_clr),
    .ch_busy          (ch_busy),
    .sample_out       (sample_out),
    .sample_out_ch    (sample_out_ch),
    .sample_out_valid (sample_out_valid),
    .overflow         (overflow)
`ifdef AVG_SCHED_DROP_CNT_EN
    ,
    .drop_cnt         (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b1;

  typedef struct {
    int ch;
    int val;
    int cyc;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input int val, input int at);
    exp_t e;
    e.ch  = ch;
    e.val = val;
    e.cyc = at;
    sb.push_back(e);
  endtask

  // Single sample on one channel, then idle long enough for it to drain.
  task automatic send(input int ch, input int v, input int expv);
    ch_sample_in[ch*word_width +: word_width] = 16'(v);
    ch_sample_valid[ch] = 1'b1;
    push(ch, expv, cyc + 2);
    tick();
    ch_sample_valid = '0;
    repeat (3) tick();
  endtask

  task automatic pulse_hist_clr();
    hist_clr = 1'b1;
    tick();
    hist_clr = 1'b0;
  endtask

  task automatic pulse_overflow_clr();
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && mon_en && sample_out_valid) begin
      chk("strobe_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("out_ch", 32'(sample_out_ch), e.ch);
        chk("out_val", 32'($signed(sample_out)), e.val);
        chk("out_cycle", cyc, e.cyc);
      end
    end
  end

  int t0;

  initial begin
    rst             = 1'b1;
    ch_enable       = '0;
    ch_sample_in    = '0;
    ch_sample_valid = '0;
    hist_clr        = 1'b0;
    overflow_clr    = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_valid", 32'(sample_out_valid), 0);
    chk("rst_out", 32'(sample_out), 0);
    chk("rst_ch", 32'(sample_out_ch), 0);
    chk("rst_busy", 32'(ch_busy), 0);
    chk("rst_overflow", 32'(overflow), 0);
`ifdef AVG_SCHED_DROP_CNT_EN
    chk("rst_drop_cnt", 32'(drop_cnt), 0);
`endif
    rst = 1'b0;
    tick();

    // Simultaneous capture from zero history: ch0 first, ch1 one cycle later.
    ch_enable       = 2'b11;
    ch_sample_in    = {16'd20, 16'd10};
    ch_sample_valid = 2'b11;
    push(0, 5, cyc + 2);
    push(1, 10, cyc + 3);
    tick();
    ch_sample_valid = '0;
    repeat (4) tick();

    // Pointer returned to 0, so ch0 wins again; histories are now 10 and 20.
    ch_sample_in    = {16'd40, 16'd30};
    ch_sample_valid = 2'b11;
    push(0, 20, cyc + 2);
    push(1, 30, cyc + 3);
    tick();
    ch_sample_valid = '0;
    repeat (4) tick();

    // Spaced samples on ch0 after a history clear.
    pulse_hist_clr();
    ch_sample_in[15:0] = 16'd100;
    ch_sample_valid    = 2'b01;
    push(0, 50, cyc + 2);
    tick();
    ch_sample_valid = '0;
    @(negedge clk);
    chk("busy_after_capture", 32'(ch_busy), 32'b01);
    tick();
    @(negedge clk);
    chk("busy_after_grant", 32'(ch_busy), 0);
    repeat (2) tick();
    send(0, 200, 150);

    // Negative values: floor rounding, then pass-through.
    send(1, -3, -2);
    send(1, -4, -4);
    ch_enable = 2'b00;
    send(1, -4, -4);

    // Contention with continuous ch1 traffic: alternating grants and drops.
    t0              = cyc;
    ch_sample_in    = {16'd11, 16'd1};
    ch_sample_valid = 2'b11;
    push(0, 1, t0 + 2);
    push(1, 11, t0 + 3);
    push(0, 2, t0 + 4);
    push(1, 13, t0 + 5);
    tick();
    @(negedge clk);
    chk("busy_both", 32'(ch_busy), 32'b11);
    ch_sample_in = {16'd12, 16'd2};
    tick();
    ch_sample_in = {16'd13, 16'd3};
    tick();
    ch_sample_in    = {16'd14, 16'd0};
    ch_sample_valid = 2'b10;
    tick();
    ch_sample_valid = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("overflow_set", 32'(overflow), 32'b11);
    chk("busy_drained", 32'(ch_busy), 0);
    pulse_overflow_clr();
    @(negedge clk);
    chk("overflow_cleared", 32'(overflow), 0);

    // History clear then a fresh average.
    pulse_hist_clr();
    ch_enable = 2'b11;
    send(0, 8, 4);

    // Reset while both slots hold samples: nothing may come out.
    ch_sample_in    = {16'd6, 16'd5};
    ch_sample_valid = 2'b11;
    tick();
    rst             = 1'b1;
    ch_sample_valid = '0;
    @(negedge clk);
    chk("midrst_busy", 32'(ch_busy), 0);
    chk("midrst_valid", 32'(sample_out_valid), 0);
    chk("midrst_out", 32'(sample_out), 0);
    chk("midrst_ch", 32'(sample_out_ch), 0);
    tick();
    rst = 1'b0;
    repeat (4) tick();

`ifdef AVG_SCHED_DROP_CNT_EN
    chk("drop_cnt_after_rst", 32'(drop_cnt), 0);
    mon_en          = 1'b0;
    ch_sample_valid = 2'b11;
    repeat (700) tick();
    ch_sample_valid = '0;
    repeat (4) tick();
    mon_en = 1'b1;
    @(negedge clk);
    chk("drop_cnt1_sat", 32'(drop_cnt[15:8]), 255);
    chk("drop_cnt0_sat", 32'(drop_cnt[7:0]), 255);
    chk("overflow_flood", 32'(overflow), 32'b11);
    pulse_overflow_clr();
    @(negedge clk);
    chk("drop_cnt_cleared", 32'(drop_cnt), 0);
    chk("overflow_flood_cleared", 32'(overflow), 0);
`endif

    chk("sb_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
